// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and defaults for the instruction fetch path
package riscv_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {S_REQ = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} fetch_state_t;
endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: sequential/target PC selection with misaligned-target detection
module next_pc_logic (
    input  logic [31:0] pc,
    input  logic        pcsel,
    input  logic [31:0] alu_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        trap
);
    always_comb begin
        pc_plus4 = pc + 32'd4;
        trap = pcsel && (alu_out[1:0] != 2'b00);
        next_pc = pcsel ? alu_out : pc_plus4;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: request/execute fetch FSM holding pc, the current instruction and the retire count
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsel,
    input  logic [31:0] alu_out,
    input  logic        ins_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halt,
    output logic [31:0] instret
);
    fetch_state_t state, next_state;
    logic [31:0] next_pc;
    logic trap, fetch_done, retire;

    next_pc_logic u_next_pc (
        .pc(pc),
        .pcsel(pcsel),
        .alu_out(alu_out),
        .pc_plus4(pc_plus4),
        .next_pc(next_pc),
        .trap(trap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc <= RESET_PC;
            ins <= NOP;
            instret <= 32'd0;
        end else begin
            state <= next_state;
            if (fetch_done) ins <= imem_rdata;
            if (retire) begin
                pc <= next_pc;
                instret <= instret + 32'd1;
            end
        end
    end

    // Outputs are gated by rst so the bus is quiet during reset, whatever state the register still holds.
    always_comb begin
        fetch_done = (state == S_REQ) && imem_ready;
        retire = (state == S_EXEC) && ins_ack && !trap;
        next_state = fetch_done ? S_EXEC
                   : (state == S_EXEC && ins_ack) ? (trap ? S_HALT : S_REQ)
                   : state;
        imem_req = !rst && (state == S_REQ);
        ins_valid = !rst && (state == S_EXEC);
        halt = !rst && (state == S_HALT);
        imem_addr = pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk, rst, pcsel, ins_ack, imem_ready;
    logic [31:0] alu_out, imem_rdata;
    logic imem_req, ins_valid, halt;
    logic [31:0] imem_addr, ins, pc, pc_plus4, instret;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_t;

    fetch_t exp_q[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] pc_m, instret_m;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pcsel(pcsel), .alu_out(alu_out), .ins_ack(ins_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid), .pc(pc),
        .pc_plus4(pc_plus4), .halt(halt), .instret(instret)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic [31:0] rdata, input string tag);
        fetch_t e;
        #1;
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, pc_m);
        chk({tag, "_nvalid"}, {31'd0, ins_valid}, 32'd0);
        imem_ready = 1;
        imem_rdata = rdata;
        exp_q.push_back('{pc: pc_m, ins: rdata});
        @(negedge clk);
        imem_ready = 0;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        e = exp_q.pop_front();
        chk({tag, "_ins"}, ins, e.ins);
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_pc4"}, pc_plus4, e.pc + 32'd4);
        chk({tag, "_valid"}, {31'd0, ins_valid}, 32'd1);
        chk({tag, "_req_off"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic ack(input logic sel, input logic [31:0] target, input string tag);
        logic trap_m;
        trap_m = sel && (target[1:0] != 2'b00);
        ins_ack = 1;
        pcsel = sel;
        alu_out = target;
        @(negedge clk);
        ins_ack = 0;
        pcsel = 1;
        alu_out = 32'h0000_0200;
        #1;
        if (trap_m) begin
            chk({tag, "_halt"}, {31'd0, halt}, 32'd1);
            chk({tag, "_pc_hold"}, pc, pc_m);
            chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
            chk({tag, "_instret"}, instret, instret_m);
        end else begin
            pc_m = sel ? target : pc_m + 32'd4;
            instret_m = instret_m + 32'd1;
            chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
            chk({tag, "_addr"}, imem_addr, pc_m);
            chk({tag, "_instret"}, instret, instret_m);
        end
    endtask

    task automatic wait_req(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
            chk({tag, "_addr"}, imem_addr, pc_m);
            chk({tag, "_nvalid"}, {31'd0, ins_valid}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1; pcsel = 0; ins_ack = 0; imem_ready = 0;
        alu_out = 32'd0; imem_rdata = 32'd0;
        pc_m = 32'd0; instret_m = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ins", ins, NOP);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 0;
        respond(32'h0050_0093, "first_fetch");

        imem_ready = 1;
        imem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        chk("exec_hold_ins", ins, 32'h0050_0093);
        chk("exec_hold_valid", {31'd0, ins_valid}, 32'd1);
        chk("exec_hold_pc", pc, 32'd0);
        imem_ready = 0;
        ack(0, 32'd0, "seq0");

        ins_ack = 1; pcsel = 1; alu_out = 32'h0000_0100;
        wait_req(3, "stall");
        ins_ack = 0;
        respond(32'h0010_0113, "after_stall");
        ack(0, 32'd0, "seq1");
        respond(32'h0020_0193, "f8");
        ack(0, 32'd0, "seq2");
        respond(32'h0030_0213, "fc");
        ack(0, 32'd0, "seq3");
        respond(32'h0400_006F, "f10");
        ack(1, 32'h0000_0040, "jump40");
        respond(32'h0000_0013, "f40");
        ack(1, 32'hFFFF_FFFC, "jump_top");
        respond(32'h0000_0033, "ftop");
        ack(0, 32'd0, "wrap");
        respond(32'h0420_0067, "fwrap");
        ack(1, 32'h0000_0042, "misalign");

        imem_ready = 1; ins_ack = 1; pcsel = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, ins_valid}, 32'd0);
        chk("halt_pc", pc, pc_m);
        chk("halt_instret", instret, instret_m);
        imem_ready = 0; ins_ack = 0;

        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_halt_clear", {31'd0, halt}, 32'd0);
        pc_m = 32'd0;
        instret_m = 32'd0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        rst = 1;
        imem_ready = 1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        chk("midfetch_rst_ins", ins, NOP);
        chk("midfetch_rst_pc", pc, 32'd0);
        chk("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
        chk("midfetch_rst_instret", instret, 32'd0);
        rst = 0;
        imem_ready = 0;
        respond(32'h0010_0093, "refetch");
        ack(0, 32'd0, "reseq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: pcsel  input  1  from control unit; 1 = take alu_out as next PC, 0 = PC+4.
REQ-005 SHALL have port: alu_out  input  32  branch/jump target computed by the ALU.
REQ-006 SHALL have port: ins_ack  input  1  datapath has finished executing the presented instruction.
REQ-007 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port: imem_addr  output  32  instruction-memory read address.
REQ-009 SHALL have port: imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word from memory.
REQ-011 SHALL have ports: ins  output  32  held instruction; ins_valid  output  1  ins is executable.
REQ-012 SHALL have ports: pc  output  32  address of ins; pc_plus4  output  32  pc+4 for JAL/JALR writeback.
REQ-013 SHALL have ports: halt  output  1  misaligned-target trap; instret  output  32  retired-instruction count.

Function
REQ-014 SHALL implement FSM with states S_REQ, S_EXEC, S_HALT.
REQ-015 S_REQ SHALL drive imem_req=1, imem_addr=pc, ins_valid=0; imem_addr SHALL stay stable until imem_ready.
REQ-016 In S_REQ with imem_ready=1 (including the first request cycle), ins SHALL latch imem_rdata and FSM SHALL enter S_EXEC next cycle; minimum fetch latency is one cycle.
REQ-017 S_EXEC SHALL drive imem_req=0, ins_valid=1, and hold ins and pc stable until ins_ack=1.
REQ-018 imem_ready SHALL be ignored outside S_REQ; ins_ack SHALL be ignored outside S_EXEC.
REQ-019 On ins_ack in S_EXEC with pcsel=0, pc SHALL become pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and FSM SHALL enter S_REQ.
REQ-020 On ins_ack with pcsel=1 and alu_out[1:0]==0, pc SHALL become alu_out and FSM SHALL enter S_REQ.
REQ-021 On ins_ack with pcsel=1 and alu_out[1:0]!=0, pc SHALL remain unchanged, halt SHALL assert next cycle, FSM SHALL enter S_HALT.
REQ-022 S_HALT SHALL drive imem_req=0, ins_valid=0, halt=1 and SHALL be left only by rst.
REQ-023 instret SHALL increment by 1 on every ins_ack in S_EXEC that does not trap, wrapping 32'hFFFF_FFFF to 0.
REQ-024 pc_plus4 SHALL equal pc+4 combinationally at all times.
REQ-025 pcsel and alu_out SHALL be sampled only in the ins_ack cycle.

Reset
REQ-026 While rst=1: FSM=S_REQ state held inactive, imem_req=0, pc=RESET_PC, ins=32'h0000_0013 (NOP), ins_valid=0, halt=0, instret=0.
REQ-027 First cycle after rst deasserts SHALL be S_REQ with imem_req=1, imem_addr=RESET_PC.
REQ-028 rst asserted mid-fetch or in S_EXEC/S_HALT SHALL abandon the request and discard any imem_ready that cycle.

Structure
REQ-029 NOP encoding, FSM state encodings and default RESET_PC SHALL live in the shared riscv_pkg package.
REQ-030 Next-PC selection and alignment check SHALL be one combinational sub-module, next_pc_logic; FSM, pc, ins and instret registers stay in fetch_unit.

Verification
REQ-031 Reset release, imem_ready=1 same cycle, rdata=32'h0050_0093 -> next cycle ins=32'h0050_0093, ins_valid=1, pc=0.
REQ-032 imem_ready held low 3 cycles -> imem_req=1, imem_addr constant for 4 cycles, ins_valid=0 throughout.
REQ-033 pc=32'h0000_0010, ins_ack, pcsel=1, alu_out=32'h0000_0040 -> next imem_addr=32'h40, instret+1.
REQ-034 pc=32'hFFFF_FFFC, ins_ack, pcsel=0 -> next imem_addr=0.
REQ-035 ins_ack, pcsel=1, alu_out=32'h0000_0042 -> halt=1, pc unchanged, imem_req=0 until rst; instret unchanged.
REQ-036 rst pulse during S_REQ with imem_ready=1 -> ins stays NOP, pc=RESET_PC, fetch restarts.
